// File: rtl/mem_wb_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_pkg
// Shared types and helpers for the MEM/WB pipeline register.
//
// The localparams here describe the default build (24-bit data, 4-bit
// destination, one slot, 16-bit retired counter). mem_wb_pipe uses them as
// its parameter defaults and re-declares the slot struct with its own
// parameter widths so that non-default builds keep the same field layout.
//
// Contents:
//   DATA_W_DEF / DEST_W_DEF / STAGES_DEF / CNT_W_DEF  default sizes
//   mem_wb_slot_t   one pipeline slot: valid, control, destination, data
//   bubble()        an empty slot (valid=0, every payload field 0)
//   slot_wb_data()  writeback data a slot would deliver (load vs ALU)
// ---------------------------------------------------------------------------
package mem_wb_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int DEST_W_DEF = 4;
  localparam int STAGES_DEF = 1;
  localparam int CNT_W_DEF  = 16;

  typedef struct packed {
    logic                  valid;
    logic                  writeback_enable;
    logic                  mem_read_enable;
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] mem_read_data;
    logic [DATA_W_DEF-1:0] alu_result;
  } mem_wb_slot_t;

  function automatic mem_wb_slot_t bubble();
    return '0;
  endfunction

  function automatic logic [DATA_W_DEF-1:0] slot_wb_data(input mem_wb_slot_t s);
    return s.mem_read_enable ? s.mem_read_data : s.alu_result;
  endfunction

endpackage

// File: rtl/mem_wb_fwd_lookup.sv
// ---------------------------------------------------------------------------
// mem_wb_fwd_lookup
// Combinational priority matcher over the MEM/WB slot array. Reports whether
// any qualifying slot targets the queried register and, if so, the writeback
// data of the youngest such slot (slot 0 is youngest).
//
// Ports:
//   slot_qual  in  [STAGES]          slot is valid and writes the register file
//   slot_dest  in  [STAGES][DEST_W]  destination register per slot
//   slot_data  in  [STAGES][DATA_W]  selected writeback data per slot
//   query      in  DEST_W            register index being looked up
//   hit        out 1                 some qualifying slot matches
//   data       out DATA_W            youngest matching slot's data, 0 on miss
// ---------------------------------------------------------------------------
module mem_wb_fwd_lookup
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic [STAGES-1:0]             slot_qual,
  input  logic [STAGES-1:0][DEST_W-1:0] slot_dest,
  input  logic [STAGES-1:0][DATA_W-1:0] slot_data,
  input  logic [DEST_W-1:0]             query,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);

  // Scan oldest to youngest so a younger match overwrites an older one;
  // the final assignment therefore comes from the youngest matching slot.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (slot_qual[k] && (slot_dest[k] == query)) begin
        hit  = 1'b1;
        data = slot_data[k];
      end
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
// Parametrised MEM/WB pipeline register between the memory stage and the
// register-file write port. Carries writeback control, destination and data
// through STAGES slots, with valid tracking, stall/flush, writeback data
// selection, a forwarding lookup across all slots and a retired counter.
//
// Parameters:
//   DATA_W  data width (load data, ALU result, writeback data)
//   DEST_W  destination register index width
//   STAGES  number of slots, 1..4; outputs lag capture by STAGES-1 edges
//   CNT_W   retired-instruction counter width (wraps)
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   stall                    hold every slot and the counter
//   flush                    load a bubble into slot 0 (beats stall there)
//   valid_in, writeback_enable, mem_read_enable, instruction_dest,
//   mem_read_data, alu_result
//                            incoming instruction from the memory stage
//   fwd_query                register index for the forwarding lookup
//   valid_out .. alu_result_out
//                            contents of the last slot
//   wb_data                  last slot's selected writeback data
//   fwd_hit, fwd_data        forwarding result over all slots
//   retired_count            instructions that have left the last slot
// ---------------------------------------------------------------------------
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DEST_W-1:0] fwd_query,
  output logic              valid_out,
  output logic              writeback_enable_out,
  output logic              mem_read_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);

  // Same layout as mem_wb_slot_t, sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic              writeback_enable;
    logic              mem_read_enable;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] alu_result;
  } slot_t;

  function automatic slot_t empty_slot();
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] sel_wb(input slot_t s);
    return s.mem_read_enable ? s.mem_read_data : s.alu_result;
  endfunction

  slot_t                         slot_p [STAGES];
  slot_t                         slot_in_p0;
  slot_t                         last_slot;
  logic                          load_p0;
  logic                          shift_p;
  logic                          retire;
  logic [STAGES-1:0]             fwd_qual;
  logic [STAGES-1:0][DEST_W-1:0] fwd_dest;
  logic [STAGES-1:0][DATA_W-1:0] fwd_wb;

  // Incoming instruction, or a bubble when it is not real or is flushed.
  always_comb begin
    slot_in_p0 = empty_slot();
    if (valid_in && !flush) begin
      slot_in_p0.valid            = 1'b1;
      slot_in_p0.writeback_enable = writeback_enable;
      slot_in_p0.mem_read_enable  = mem_read_enable;
      slot_in_p0.dest             = instruction_dest;
      slot_in_p0.mem_read_data    = mem_read_data;
      slot_in_p0.alu_result       = alu_result;
    end
  end

  // Slot 0 reloads on flush even while stalled; older slots only shift
  // when not stalled. With one slot, a flush during stall still pushes the
  // resident instruction out, so it counts as retired.
  assign load_p0   = !stall || flush;
  assign shift_p   = !stall;
  assign last_slot = slot_p[STAGES-1];
  assign retire    = last_slot.valid && ((STAGES == 1) ? load_p0 : shift_p);

  // ---- slot 0 capture / slots 1..STAGES-1 shift ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        slot_p[k] <= empty_slot();
      end
      retired_count <= '0;
    end else begin
      if (load_p0) begin
        slot_p[0] <= slot_in_p0;
      end
      if (shift_p) begin
        for (int k = 1; k < STAGES; k++) begin
          slot_p[k] <= slot_p[k-1];
        end
      end
      if (retire) begin
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

  // ---- last slot to register-file write port ----
  assign valid_out            = last_slot.valid;
  assign writeback_enable_out = last_slot.valid && last_slot.writeback_enable;
  assign mem_read_enable_out  = last_slot.mem_read_enable;
  assign instruction_dest_out = last_slot.dest;
  assign mem_read_data_out    = last_slot.mem_read_data;
  assign alu_result_out       = last_slot.alu_result;
  assign wb_data              = sel_wb(last_slot);

  // Flatten slot contents for the forwarding matcher.
  always_comb begin
    fwd_qual = '0;
    fwd_dest = '0;
    fwd_wb   = '0;
    for (int k = 0; k < STAGES; k++) begin
      fwd_qual[k] = slot_p[k].valid && slot_p[k].writeback_enable;
      fwd_dest[k] = slot_p[k].dest;
      fwd_wb[k]   = sel_wb(slot_p[k]);
    end
  end

  mem_wb_fwd_lookup #(
    .DATA_W (DATA_W),
    .DEST_W (DEST_W),
    .STAGES (STAGES)
  ) u_fwd_lookup (
    .slot_qual (fwd_qual),
    .slot_dest (fwd_dest),
    .slot_data (fwd_wb),
    .query     (fwd_query),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline register, successor to the fixed 24-bit single-stage MEM-to-WB register.
- Carries writeback control, destination and data through STAGES register slots (for multi-cycle memory).
- Adds valid tracking, stall/flush, writeback data selection, a forwarding lookup across all slots, and a retired-instruction counter.
- Sits between the memory stage and the register file write port.

Parameters:
- DATA_W, 24, width of mem_read_data / alu_result / wb_data.
- DEST_W, 4, width of destination register index.
- STAGES, 1, number of register slots (legal 1..4); sets latency.
- CNT_W, 16, width of retired counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all slots.
- flush  in  1  replace the incoming instruction with a bubble.
- valid_in  in  1  input instruction is real.
- writeback_enable  in  1  instruction writes the register file.
- mem_read_enable  in  1  writeback source is memory (else ALU).
- instruction_dest  in  DEST_W  destination register.
- mem_read_data  in  DATA_W  load data.
- alu_result  in  DATA_W  ALU result.
- fwd_query  in  DEST_W  register index for the forwarding lookup.
- valid_out  out  1  last slot valid.
- writeback_enable_out  out  1  last slot writeback_enable AND valid.
- mem_read_enable_out  out  1  last slot mem_read_enable.
- instruction_dest_out  out  DEST_W  last slot destination.
- mem_read_data_out  out  DATA_W  last slot load data.
- alu_result_out  out  DATA_W  last slot ALU result.
- wb_data  out  DATA_W  mem_read_enable_out ? mem_read_data_out : alu_result_out.
- fwd_hit  out  1  some valid slot with writeback_enable has dest == fwd_query.
- fwd_data  out  DATA_W  selected writeback data of the youngest matching slot; 0 if no hit.
- retired_count  out  CNT_W  instructions leaving the last slot.

Behaviour:
- Reset (sync, rst=1 at edge): every slot's valid and payload are cleared to 0, and retired_count is 0.
  - So all outputs are 0 the cycle after; fwd_hit=0.
  - rst overrides stall and flush.
  - Mid-operation reset discards in-flight instructions without counting them.
- Slot 0 is the youngest; slot STAGES-1 drives the outputs. Latency: an input captured at edge N appears at the outputs after edge N+STAGES-1 (STAGES=1: visible right after the capture edge).
- Normal (no rst, no stall, no flush): slot0 <= {valid_in, inputs}; slot k <= slot k-1.
- Bubble: valid=0 with all payload fields 0. It is loaded into slot0 when valid_in=0 or flush=1.
- Stall (flush=0): all slots hold; retired_count holds.
- Flush has priority over stall: slot0 loads a bubble; slots 1..STAGES-1 follow the stall/shift rule as if flush were absent.
- Retire: retired_count += 1 (mod 2^CNT_W, wraps 0xFFFF->0 for CNT_W=16) on each edge where the last slot is valid and stall=0 (or flush=1 with STAGES=1).
- Forwarding is combinational over the current slot contents.
  - Priority: slot 0 beats slot 1 beats ... slot STAGES-1.
  - Only valid slots with writeback_enable qualify. dest 0 is an ordinary register.
- wb_data is combinational from the last slot.

Decomposition:
- Package mem_wb_pkg holds:
  - typedef mem_wb_slot_t: packed struct {valid, writeback_enable, mem_read_enable, dest, mem_read_data, alu_result}.
  - function bubble().
  - function slot_wb_data(slot).
- The package is parametrised via localparams matching the defaults; the top overrides them through a parameterised struct in the module.
- One natural sub-module: mem_wb_fwd_lookup, a priority matcher over the slot array.

Test Plan:
- Default params, rst=1 for 2 cycles -> all outputs 0, retired_count=0. Then valid_in=1, we=1, dest=1, alu=1 -> next edge: writeback_enable_out=1, dest_out=1, wb_data=1, retired_count=1 one edge later.
- Load select: mem_read_enable=1, mem_read_data=2, alu=1, dest=2 -> wb_data=2. Then mem_read_enable=0, alu=3, dest=3 -> wb_data=3.
- STAGES=3, single instruction dest=5, alu=0x00ABCD -> outputs appear 2 edges after capture. fwd_query=5 gives fwd_hit=1, fwd_data=0x00ABCD while in any slot. fwd_query=6 -> fwd_hit=0, fwd_data=0.
- STAGES=2, two back-to-back writes to dest=4 with alu=0x10 then 0x20 -> fwd_data=0x20 (youngest wins).
- Stall and flush:
  - stall=1 for 3 cycles -> outputs and retired_count frozen.
  - stall=1 and flush=1 with STAGES=2 -> slot0 becomes a bubble, slot1 holds, count unchanged.
  - rst asserted mid-stream -> next edge all outputs 0, count 0.
- Counter wrap with CNT_W=4: 17 valid retirements -> retired_count=1.
